// File: rtl/ram_read_sequencer.sv
// Reads a contiguous range from a synchronous word RAM and delivers each word on a valid/ready port.
// Optional macro READER_TICK_EN: after each non-final transfer, wait for step_tick before the next read.
module ram_read_sequencer #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] count,
  input  logic              step_tick,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rden,
  input  logic [DATA_W-1:0] ram_q,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ISSUE = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] HOLD  = 3'd3;
  localparam logic [2:0] PACE  = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] remaining_q, remaining_d;
  logic [DATA_W-1:0] data_q, data_d;

`ifndef READER_TICK_EN
  logic unused_step_tick;
  assign unused_step_tick = step_tick;
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    data_d      = data_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d      = base_addr;
          remaining_d = count;
          state_d     = (count == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        // RAM data is valid in the cycle after the address was issued
        data_d  = ram_q;
        state_d = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          remaining_d = remaining_q - ADDR_W'(1);
          addr_d      = addr_q + ADDR_W'(1);
          if (remaining_q == ADDR_W'(1)) begin
            state_d = DONE;
          end else begin
`ifdef READER_TICK_EN
            state_d = PACE;
`else
            state_d = ISSUE;
`endif
          end
        end
      end
`ifdef READER_TICK_EN
      PACE: begin
        if (step_tick) state_d = ISSUE;
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      data_q      <= data_d;
    end
  end

  // Outputs decode from state so reset clears them immediately
  assign ram_addr  = addr_q;
  assign ram_rden  = (state_q == ISSUE);
  assign out_data  = data_q;
  assign out_valid = (state_q == HOLD);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_ram_read_sequencer.sv
// Directed self-checking bench for ram_read_sequencer with a tiny synchronous RAM model.
// The paced-readout scenario is compiled only when READER_TICK_EN is defined.
module tb_ram_read_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] base_addr = '0;
  logic [15:0] count = '0;
  logic        step_tick = 1'b0;
  logic [15:0] ram_addr;
  logic        ram_rden;
  logic [31:0] ram_q = '0;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

  logic        tr_rden[64];
  logic [15:0] tr_addr[64];
  logic        tr_valid[64];
  logic [31:0] tr_data[64];
  logic        tr_done[64];
  logic        tr_busy[64];

  ram_read_sequencer #(.ADDR_W(16), .DATA_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .count     (count),
    .step_tick (step_tick),
    .ram_addr  (ram_addr),
    .ram_rden  (ram_rden),
    .ram_q     (ram_q),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // mem[a] = 0xA5000000 | a, one-cycle read latency
  always @(posedge clk) ram_q <= 32'hA500_0000 | {16'h0000, ram_addr};

  // Start a sequence and record ncyc cycles of outputs; cycle 0 is the one after the start edge.
  task automatic run_seq(input logic [15:0] b, input logic [15:0] n, input int stall_word,
                         input int stall_n, input int ncyc, input bit tick_mode);
    int xfer;
    int left;
    xfer = 0;
    left = stall_n;
    base_addr = b;
    count = n;
    start = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      tr_rden[c]  = ram_rden;
      tr_addr[c]  = ram_addr;
      tr_valid[c] = out_valid;
      tr_data[c]  = out_data;
      tr_done[c]  = done;
      tr_busy[c]  = busy;
      out_ready = 1'b1;
      if (out_valid && xfer == stall_word && left > 0) begin
        out_ready = 1'b0;
        left--;
      end
      if (out_valid && out_ready) xfer++;
      step_tick = tick_mode && (c % 10 == 9);
      start = tick_mode && (c == 4);
      @(posedge clk); #1;
    end
    step_tick = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++) begin
      start = i[0];
      @(posedge clk); #1;
      checks++;
      if ({ram_addr, ram_rden, out_data, out_valid, busy, done} !== '0) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: addr=%h rden=%b data=%h valid=%b busy=%b done=%b, want all 0",
                 i, ram_addr, ram_rden, out_data, out_valid, busy, done);
      end
    end
    start = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_sequence();
    int n;
    run_seq(16'h0010, 16'd3, -1, 0, 12, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (tr_rden[3*i] !== 1'b1 || tr_addr[3*i] !== 16'h0010 + 16'(i)) begin
        errors++;
        $display("FAIL seq_issue %0d: rden=%b addr=%h, want 1 %h", i, tr_rden[3*i], tr_addr[3*i],
                 16'h0010 + 16'(i));
      end
      checks++;
      if (tr_valid[3*i+2] !== 1'b1 || tr_data[3*i+2] !== 32'hA500_0010 + 32'(i)) begin
        errors++;
        $display("FAIL seq_word %0d: valid=%b data=%h, want 1 %h", i, tr_valid[3*i+2],
                 tr_data[3*i+2], 32'hA500_0010 + 32'(i));
      end
    end
    n = 0;
    for (int c = 0; c < 12; c++) if (tr_rden[c] === 1'b1) n++;
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL seq_rden_count: got %0d, want 3", n);
    end
    n = 0;
    for (int c = 0; c < 12; c++) if (tr_done[c] === 1'b1) n++;
    checks++;
    if (n != 1 || tr_done[9] !== 1'b1 || tr_busy[9] !== 1'b1 || tr_busy[10] !== 1'b0) begin
      errors++;
      $display("FAIL seq_done: pulses=%0d done9=%b busy9=%b busy10=%b, want 1 1 1 0", n, tr_done[9],
               tr_busy[9], tr_busy[10]);
    end
  endtask

  task automatic test_backpressure();
    int n;
    run_seq(16'h0010, 16'd3, 1, 5, 16, 1'b0);
    n = 0;
    for (int c = 5; c <= 10; c++)
      if (tr_valid[c] === 1'b1 && tr_data[c] === 32'hA500_0011 && tr_rden[c] === 1'b0) n++;
    checks++;
    if (n != 6) begin
      errors++;
      $display("FAIL bp_hold: stable cycles=%0d, want 6", n);
    end
    checks++;
    if (tr_rden[4] !== 1'b0 || tr_rden[11] !== 1'b1 || tr_addr[11] !== 16'h0012) begin
      errors++;
      $display("FAIL bp_next_issue: rden4=%b rden11=%b addr11=%h, want 0 1 0012", tr_rden[4],
               tr_rden[11], tr_addr[11]);
    end
    checks++;
    if (tr_data[13] !== 32'hA500_0012 || tr_done[14] !== 1'b1) begin
      errors++;
      $display("FAIL bp_tail: data13=%h done14=%b, want a5000012 1", tr_data[13], tr_done[14]);
    end
  endtask

  task automatic test_wrap_empty();
    int n;
    run_seq(16'hFFFE, 16'd3, -1, 0, 12, 1'b0);
    checks++;
    if (tr_addr[0] !== 16'hFFFE || tr_addr[3] !== 16'hFFFF || tr_addr[6] !== 16'h0000 ||
        tr_rden[6] !== 1'b1) begin
      errors++;
      $display("FAIL wrap_addr: %h %h %h rden6=%b, want fffe ffff 0000 1", tr_addr[0], tr_addr[3],
               tr_addr[6], tr_rden[6]);
    end
    checks++;
    if (tr_data[8] !== 32'hA500_0000 || tr_done[9] !== 1'b1) begin
      errors++;
      $display("FAIL wrap_word: data8=%h done9=%b, want a5000000 1", tr_data[8], tr_done[9]);
    end
    run_seq(16'h0040, 16'd0, -1, 0, 4, 1'b0);
    checks++;
    if (tr_done[0] !== 1'b1 || tr_busy[1] !== 1'b0 || tr_done[1] !== 1'b0) begin
      errors++;
      $display("FAIL empty_done: done0=%b busy1=%b done1=%b, want 1 0 0", tr_done[0], tr_busy[1],
               tr_done[1]);
    end
    n = 0;
    for (int c = 0; c < 4; c++) if (tr_rden[c] === 1'b1 || tr_valid[c] === 1'b1) n++;
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL empty_quiet: rden/valid cycles=%0d, want 0", n);
    end
  endtask

  task automatic test_reset_mid_hold();
    run_seq(16'h0010, 16'd3, 1, 20, 7, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hA500_0011) begin
      errors++;
      $display("FAIL midhold_setup: valid=%b data=%h, want 1 a5000011", out_valid, out_data);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({ram_addr, ram_rden, out_data, out_valid, busy, done} !== '0) begin
      errors++;
      $display("FAIL midhold_reset: addr=%h rden=%b data=%h valid=%b busy=%b done=%b, want all 0",
               ram_addr, ram_rden, out_data, out_valid, busy, done);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    run_seq(16'h0020, 16'd1, -1, 0, 6, 1'b0);
    checks++;
    if (tr_valid[2] !== 1'b1 || tr_data[2] !== 32'hA500_0020 || tr_done[3] !== 1'b1 ||
        tr_busy[4] !== 1'b0) begin
      errors++;
      $display("FAIL restart_single: valid2=%b data2=%h done3=%b busy4=%b, want 1 a5000020 1 0",
               tr_valid[2], tr_data[2], tr_done[3], tr_busy[4]);
    end
  endtask

`ifdef READER_TICK_EN
  task automatic test_tick_pacing();
    int n;
    run_seq(16'h0030, 16'd3, -1, 0, 26, 1'b1);
    n = 0;
    for (int c = 0; c < 26; c++) if (tr_rden[c] === 1'b1) n++;
    checks++;
    if (n != 3 || tr_rden[0] !== 1'b1 || tr_rden[10] !== 1'b1 || tr_rden[20] !== 1'b1) begin
      errors++;
      $display("FAIL tick_issue: pulses=%0d r0=%b r10=%b r20=%b, want 3 1 1 1", n, tr_rden[0],
               tr_rden[10], tr_rden[20]);
    end
    checks++;
    if (tr_data[22] !== 32'hA500_0032 || tr_done[23] !== 1'b1 || tr_addr[20] !== 16'h0032) begin
      errors++;
      $display("FAIL tick_tail: data22=%h done23=%b addr20=%h, want a5000032 1 0032", tr_data[22],
               tr_done[23], tr_addr[20]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_sequence();
    test_backpressure();
    test_wrap_empty();
    test_reset_mid_hold();
`ifdef READER_TICK_EN
    test_tick_pacing();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
